// File: rtl/led_pkg.sv
// Shared types and panel-pin widths for the BCM LED matrix driver.
package led_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StLatch,
        StDisplay,
        StNext,
        StDone
    } state_e;

    localparam int unsigned RGB_PINS  = 3;
    localparam int unsigned CTRL_PINS = 3;

endpackage

// File: rtl/ram.sv
// Simple dual-port frame RAM: synchronous write, registered read (one-cycle latency).
module ram #(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned ADDR_BITS = 9
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/bcm_matrix_driver.sv
// Binary-code-modulation scan driver for a dual-half HUB75-style LED panel.
// All panel pins are registered, so they trail the FSM state by one cycle.
module bcm_matrix_driver
    import led_pkg::*;
#(
    parameter int unsigned CDEPTH        = 4,
    parameter int unsigned ROW_BITS      = 4,
    parameter int unsigned COL_BITS      = 5,
    parameter int unsigned MCLK_DIV_BITS = 3,
    parameter int unsigned BASE_TICKS    = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we,
    input  logic [ROW_BITS+COL_BITS:0]     waddr,
    input  logic [3*CDEPTH-1:0]            wpix,
    input  logic                           fstart,
    input  logic                           auto_repeat,
    output logic                           fend,
    output logic                           busy,
    output logic [RGB_PINS-1:0]            rgb_lo,
    output logic [RGB_PINS-1:0]            rgb_hi,
    output logic [ROW_BITS-1:0]            row,
    output logic                           mclk,
    output logic                           latch,
    output logic                           oe_n
);

    localparam int unsigned PIX_W   = 3 * CDEPTH;
    localparam int unsigned ADDR_W  = ROW_BITS + COL_BITS;
    localparam int unsigned PLANE_W = (CDEPTH > 1) ? $clog2(CDEPTH) : 1;
    localparam int unsigned TICK_W  = $clog2((BASE_TICKS << (CDEPTH - 1)) + 1);
    localparam int unsigned IDX_W   = $clog2(PIX_W);
    localparam logic [PLANE_W-1:0] LastPlane = PLANE_W'(CDEPTH - 1);

    state_e                   state_q, state_d;
    logic [ROW_BITS-1:0]      row_q, row_d;
    logic [COL_BITS-1:0]      col_q, col_d;
    logic [PLANE_W-1:0]       plane_q, plane_d;
    logic [MCLK_DIV_BITS-1:0] div_q, div_d;
    logic [TICK_W-1:0]        ticks_q, ticks_d;

    logic [CTRL_PINS-1:0]     ctrl_q, ctrl_d;
    logic                     fend_q, fend_d, busy_q, busy_d;
    logic [RGB_PINS-1:0]      rgb_lo_q, rgb_lo_d, rgb_hi_q, rgb_hi_d;
    logic [ROW_BITS-1:0]      row_out_q;

    logic [PIX_W-1:0]         lo_rdata, hi_rdata;
    logic                     wr_ok;

    assign wr_ok = we && (state_q == StIdle);

    ram #(
        .WIDTH     (PIX_W),
        .ADDR_BITS (ADDR_W)
    ) u_ram_lo (
        .clk   (clk),
        .we    (wr_ok && !waddr[ADDR_W]),
        .waddr (waddr[ADDR_W-1:0]),
        .wdata (wpix),
        .raddr ({row_q, col_q}),
        .rdata (lo_rdata)
    );

    ram #(
        .WIDTH     (PIX_W),
        .ADDR_BITS (ADDR_W)
    ) u_ram_hi (
        .clk   (clk),
        .we    (wr_ok && waddr[ADDR_W]),
        .waddr (waddr[ADDR_W-1:0]),
        .wdata (wpix),
        .raddr ({row_q, col_q}),
        .rdata (hi_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            row_q     <= '0;
            col_q     <= '0;
            plane_q   <= '0;
            div_q     <= '0;
            ticks_q   <= '0;
            ctrl_q    <= 3'b100;
            fend_q    <= 1'b0;
            busy_q    <= 1'b0;
            rgb_lo_q  <= '0;
            rgb_hi_q  <= '0;
            row_out_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            plane_q   <= plane_d;
            div_q     <= div_d;
            ticks_q   <= ticks_d;
            ctrl_q    <= ctrl_d;
            fend_q    <= fend_d;
            busy_q    <= busy_d;
            rgb_lo_q  <= rgb_lo_d;
            rgb_hi_q  <= rgb_hi_d;
            row_out_q <= row_q;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        plane_d = plane_q;
        div_d   = div_q;
        ticks_d = ticks_q;
        case (state_q)
            StIdle: begin
                if (fstart) begin
                    state_d = StShift;
                    row_d   = '0;
                    col_d   = '0;
                    plane_d = '0;
                    div_d   = '0;
                    ticks_d = '0;
                end
            end
            StShift: begin
                div_d = div_q + 1'b1;
                if (&div_q) begin
                    col_d = col_q + 1'b1;
                    if (&col_q) begin
                        state_d = StLatch;
                    end
                end
            end
            // Divider wrapped to zero on leaving SHIFT and times the latch pulse.
            StLatch: begin
                div_d = div_q + 1'b1;
                if (&div_q) begin
                    state_d = StDisplay;
                    ticks_d = TICK_W'((BASE_TICKS << plane_q) - 1);
                end
            end
            StDisplay: begin
                if (ticks_q == '0) begin
                    if (plane_q == LastPlane) begin
                        state_d = StNext;
                    end else begin
                        plane_d = plane_q + 1'b1;
                        state_d = StShift;
                    end
                end else begin
                    ticks_d = ticks_q - 1'b1;
                end
            end
            StNext: begin
                plane_d = '0;
                row_d   = row_q + 1'b1;
                state_d = (&row_q) ? StDone : StShift;
            end
            StDone: begin
                state_d = auto_repeat ? StShift : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        logic [IDX_W-1:0] idx;
        idx      = '0;
        ctrl_d   = {(state_q != StDisplay), (state_q == StLatch),
                    (state_q == StShift) && div_q[MCLK_DIV_BITS-1]};
        fend_d   = (state_q == StDone);
        busy_d   = (state_q != StIdle);
        rgb_lo_d = '0;
        rgb_hi_d = '0;
        for (int c = 0; c < int'(RGB_PINS); c++) begin
            idx         = IDX_W'(c * CDEPTH) + IDX_W'(plane_q);
            rgb_lo_d[c] = lo_rdata[idx];
            rgb_hi_d[c] = hi_rdata[idx];
        end
    end

    assign {oe_n, latch, mclk} = ctrl_q;
    assign fend   = fend_q;
    assign busy   = busy_q;
    assign rgb_lo = rgb_lo_q;
    assign rgb_hi = rgb_hi_q;
    assign row    = row_out_q;

endmodule

// File: doc/bcm_matrix_driver.md
BCM_MATRIX_DRIVER -- requirements
Module: bcm_matrix_driver

Interface
REQ-001 SHALL have parameter CDEPTH, default 4, bits per colour channel (pixel = 3*CDEPTH bits, R at LSBs, then G, then B).
REQ-002 SHALL have parameter ROW_BITS, default 4, log2 of rows per half-panel.
REQ-003 SHALL have parameter COL_BITS, default 5, log2 of columns.
REQ-004 SHALL have parameter MCLK_DIV_BITS, default 3, mclk divider width, legal values >= 2.
REQ-005 SHALL have parameter BASE_TICKS, default 64, clk cycles the LSB plane is displayed.
REQ-006 clk  in  1  system clock, all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 we  in  1  frame-buffer write enable.
REQ-009 waddr  in  ROW_BITS+COL_BITS+1  pixel address; MSB=1 selects lower half-panel, remaining bits {row,col}.
REQ-010 wpix  in  3*CDEPTH  pixel write data.
REQ-011 fstart  in  1  start one frame scan.
REQ-012 auto_repeat  in  1  rescan continuously without fstart.
REQ-013 fend  out  1  one-cycle pulse at frame completion.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 rgb_lo, rgb_hi  out  3 each  panel R1G1B1 / R2G2B2, bit0 = red.
REQ-016 row  out  ROW_BITS  panel row-select (A..D).
REQ-017 mclk, latch, oe_n  out  1 each  panel clock, latch, active-low output enable.

Function
REQ-018 States SHALL be IDLE, SHIFT, LATCH, DISPLAY, NEXT, DONE.
REQ-019 IDLE: we=1 SHALL write wpix to the half selected by waddr MSB; we SHALL be ignored in all other states.
REQ-020 IDLE, fstart=1 -> SHIFT, clearing row, col, plane, divider and tick counter; fstart outside IDLE SHALL be ignored.
REQ-021 SHIFT: divider increments each cycle; mclk = divider MSB (0 in all other states); col increments when divider=='1; col=='1 and divider=='1 -> LATCH.
REQ-022 Both half RAMs SHALL be read at {row,col} with one-cycle latency; rgb_lo[c] = lo_pix[c*CDEPTH+plane], likewise for rgb_hi.
REQ-023 LATCH: latch=1 for exactly 2^MCLK_DIV_BITS cycles -> DISPLAY, tick counter loaded with (BASE_TICKS<<plane)-1.
REQ-024 DISPLAY: oe_n=0 for exactly BASE_TICKS<<plane cycles; then plane==CDEPTH-1 -> NEXT, else plane+1 -> SHIFT.
REQ-025 oe_n SHALL be 1 in every state except DISPLAY; row SHALL change only in NEXT (blanked).
REQ-026 NEXT: plane=0; row=='1 -> DONE with row wrapping to 0, else row+1 -> SHIFT.
REQ-027 DONE: fend=1 for one cycle; auto_repeat=1 -> SHIFT, else -> IDLE.
REQ-028 Tick and divider widths SHALL accommodate BASE_TICKS<<(CDEPTH-1) without overflow.

Reset
REQ-029 reset SHALL force, next cycle: state IDLE, row/col/plane/divider/ticks 0, oe_n=1, latch=0, mclk=0, fend=0, busy=0, rgb outputs 0.
REQ-030 reset mid-frame SHALL abort the scan as REQ-029; RAM contents SHALL be retained.

Structure
REQ-031 State enum and the panel-pin bundle width constants SHALL live in shared package led_pkg.
REQ-032 Frame storage SHALL use two instances of sub-module ram (width 3*CDEPTH, depth 2^(ROW_BITS+COL_BITS)), one per half.

Verification (CDEPTH=2, ROW_BITS=1, COL_BITS=2, MCLK_DIV_BITS=2, BASE_TICKS=4)
REQ-033 Assert reset 2 cycles -> oe_n=1, latch=0, mclk=0, fend=0, busy=0, row=0.
REQ-034 Write waddr=0 wpix=R3, waddr=1 wpix=R2, waddr=8 wpix=B1; fstart -> plane0 col0 rgb_lo=001, col1 rgb_lo=000, rgb_hi col0=100; plane1 col0 and col1 rgb_lo=001, rgb_hi col0=000, all sampled at mclk rise.
REQ-035 Single frame -> per row oe_n low 4 then 8 cycles, latch high 4 cycles twice; fend pulses exactly 107 cycles after fstart sampled; busy drops next cycle.
REQ-036 we=1 waddr=0 wpix=FFF while busy -> RAM unchanged; next frame shows R3 data.
REQ-037 auto_repeat=1 -> fend every 107 cycles, SHIFT follows DONE with no fstart, row wraps 1->0.
REQ-038 reset during DISPLAY -> oe_n=1 and busy=0 next cycle; new fstart reproduces REQ-034 output.
